// File: rtl/even_par_chk_rx.sv
// Serial even-parity frame receiver: n data bits LSB first, then one parity bit.
// Define EVEN_PAR_CHK_ERR_CNT_EN to add the saturating 8-bit parity error counter err_cnt.
module even_par_chk_rx #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         sof,
    output logic [n-1:0] data_out,
    output logic         out_valid,
    output logic         par_err,
`ifdef EVEN_PAR_CHK_ERR_CNT_EN
    output logic [7:0]   err_cnt,
`endif
    output logic         busy
);

    localparam int CNT_W = $clog2(n) + 1;

    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [n-1:0]       shreg_q, shreg_d;
    logic [n-1:0]       data_out_q;
    logic               out_valid_q;
    logic               par_err_q;
    logic               busy_q;
    logic               done_d;
    logic               perr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        perr_d  = (^shreg_q) ^ bit_in;
        if (bit_valid) begin
            // sof always restarts, discarding any partial frame
            if (sof) begin
                shreg_d[0] = bit_in;
                cnt_d      = CNT_W'(1);
                state_d    = DATA;
            end else begin
                case (state_q)
                    DATA: begin
                        for (int i = 0; i < n; i++) begin
                            if (cnt_q == CNT_W'(i)) shreg_d[i] = bit_in;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(n - 1)) state_d = PAR;
                    end
                    PAR: begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            par_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= done_d;
            busy_q      <= (state_d != IDLE);
            if (done_d) begin
                data_out_q <= shreg_q;
                par_err_q  <= perr_d;
            end
        end
    end

`ifdef EVEN_PAR_CHK_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (done_d && perr_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign par_err   = par_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_even_par_chk_rx.sv
// Scoreboard bench for even_par_chk_rx (n=8); frames push expectations, the monitor pops them on out_valid.
module tb_even_par_chk_rx;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] data_out;
    logic       out_valid;
    logic       par_err;
    logic       busy;
`ifdef EVEN_PAR_CHK_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    exp_t sb[$];
    int   tests_run = 0;
    int   fails = 0;
    int   pulses = 0;

    even_par_chk_rx #(.n(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .sof       (sof),
        .data_out  (data_out),
        .out_valid (out_valid),
        .par_err   (par_err),
`ifdef EVEN_PAR_CHK_ERR_CNT_EN
        .err_cnt   (err_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            exp_t e;
            pulses++;
            tests_run++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: got out_valid=1 data_out=%h, expected no pulse", data_out);
            end else begin
                e = sb.pop_front();
                if (data_out !== e.d) begin
                    fails++;
                    $display("FAIL data_out: got %h expected %h", data_out, e.d);
                end
                tests_run++;
                if (par_err !== e.p) begin
                    fails++;
                    $display("FAIL par_err: got %b expected %b (data %h)", par_err, e.p, e.d);
                end
            end
        end
    end

    task automatic drive(input logic b, input logic s);
        bit_in    = b;
        sof       = s;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic idle(input int cycles, input logic sof_noise);
        for (int k = 0; k < cycles; k++) begin
            sof = sof_noise;
            bit_in = $urandom_range(0, 1);
            @(posedge clk);
            #1;
            sof = 1'b0;
        end
    endtask

    // Gaps carry sof=1 with bit_valid=0, which must be ignored; busy must stay high.
    task automatic send_frame(input logic [7:0] d, input logic p, input int gap, input logic ep);
        for (int i = 0; i < 8; i++) begin
            drive(d[i], logic'(i == 0));
            for (int g = 0; g < gap; g++) begin
                idle(1, 1'b1);
                tests_run++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL busy_gap: got %b expected 1 (bit %0d)", busy, i);
                end
            end
        end
        sb.push_back('{d: d, p: ep});
        drive(p, 1'b0);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 6) begin
            @(posedge clk);
            #1;
            k++;
        end
        @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_missing_pulse: got %0d outstanding frames, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_pulses(input string name, input int p0, input int exp_n);
        tests_run++;
        if (pulses - p0 != exp_n) begin
            fails++;
            $display("FAIL %s_pulse_count: got %0d expected %0d", name, pulses - p0, exp_n);
        end
    endtask

    task automatic test_reset();
        #3;
        tests_run++;
        if ({data_out, out_valid, par_err, busy} !== 11'h0) begin
            fails++;
            $display("FAIL reset_outputs: got data_out=%h ov=%b pe=%b busy=%b expected all 0",
                     data_out, out_valid, par_err, busy);
        end
`ifdef EVEN_PAR_CHK_ERR_CNT_EN
        tests_run++;
        if (err_cnt !== 8'h00) begin
            fails++;
            $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int p0 = pulses;
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        drain("basic");
        idle(3, 1'b0);
        tests_run++;
        if (out_valid !== 1'b0 || data_out !== 8'hA5 || par_err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_hold: got ov=%b data_out=%h pe=%b busy=%b expected 0/a5/0/0",
                     out_valid, data_out, par_err, busy);
        end
        check_pulses("basic", p0, 1);
    endtask

    task automatic test_parity_errors();
        int p0 = pulses;
`ifdef EVEN_PAR_CHK_ERR_CNT_EN
        logic [7:0] e0 = err_cnt;
`endif
        send_frame(8'hA5, 1'b1, 0, 1'b1);
        idle(2, 1'b0);
        send_frame(8'h07, 1'b0, 0, 1'b1);
        drain("parity");
        check_pulses("parity", p0, 2);
`ifdef EVEN_PAR_CHK_ERR_CNT_EN
        tests_run++;
        if (err_cnt !== e0 + 8'd2) begin
            fails++;
            $display("FAIL err_cnt_two: got %0d expected %0d", err_cnt, e0 + 8'd2);
        end
`endif
    endtask

    task automatic test_gaps();
        int p0 = pulses;
        send_frame(8'h3C, 1'b0, 3, 1'b0);
        drain("gaps");
        check_pulses("gaps", p0, 1);
    endtask

    task automatic test_restart();
        int p0 = pulses;
        drive(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
        send_frame(8'h01, 1'b1, 0, 1'b0);
        drain("restart");
        check_pulses("restart", p0, 1);
    endtask

    task automatic test_reset_mid_frame();
        int p0 = pulses;
        drive(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_mid_frame: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #2;
        tests_run++;
        if ({data_out, out_valid, par_err, busy} !== 11'h0) begin
            fails++;
            $display("FAIL async_reset: got data_out=%h ov=%b pe=%b busy=%b expected all 0",
                     data_out, out_valid, par_err, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL no_sof_ignored: got busy=%b expected 0", busy);
        end
        send_frame(8'hFF, 1'b0, 0, 1'b0);
        drain("reset_mid");
        check_pulses("reset_mid", p0, 1);
    endtask

    task automatic test_back_to_back();
        int p0 = pulses;
        for (int f = 0; f < 6; f++) begin
            logic [7:0] d = 8'($urandom);
            logic       p = 1'($urandom);
            send_frame(d, p, 0, (^d) ^ p);
        end
        drain("b2b");
        check_pulses("b2b", p0, 6);
    endtask

`ifdef EVEN_PAR_CHK_ERR_CNT_EN
    task automatic test_err_saturation();
        for (int f = 0; f < 300; f++) begin
            logic [7:0] d = 8'(f);
            send_frame(d, ~(^d), 0, 1'b1);
            if (f == 99) begin
                drain("sat_mid");
                tests_run++;
                if (err_cnt !== 8'd255 && err_cnt < 8'd100) begin
                    fails++;
                    $display("FAIL err_cnt_progress: got %0d expected >= 100", err_cnt);
                end
            end
        end
        drain("sat");
        tests_run++;
        if (err_cnt !== 8'd255) begin
            fails++;
            $display("FAIL err_cnt_saturate: got %0d expected 255", err_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_parity_errors();
        test_gaps();
        test_restart();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef EVEN_PAR_CHK_ERR_CNT_EN
        test_err_saturation();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
